// File: rtl/clk_sw_ctrl.sv
// ============================================================================
// clk_sw_ctrl : glitch-free clock-source switch sequencer (break-before-make).
// Optional build macro CLK_SW_TIMEOUT_EN adds DISABLE/ENABLE wait timeouts.
// Revision: 1.0
// ============================================================================
`default_nettype none

module clk_sw_ctrl #(
   parameter int DWELL_CYCLES   = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic [1:0] req_sel,
   output logic       req_ready,
   input  logic [3:0] sts,
   output logic [3:0] en,
   output logic [1:0] cur_sel,
   output logic       busy,
   output logic       done,
   output logic       err,
   input  logic       err_clr
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DISABLE = 2'd1,
      ST_ENABLE  = 2'd2,
      ST_SETTLE  = 2'd3
   } state_t;

   function automatic logic [3:0] onehot(input logic [1:0] s);
      return 4'b0001 << s;
   endfunction

   state_t     state_q, state_d;
   logic [1:0] target_q, target_d;
   logic [3:0] en_q, en_d;
   logic [1:0] cur_sel_q, cur_sel_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic       busy_q, busy_d;
   logic [7:0] dwell_q, dwell_d;
   logic [1:0] rst_pipe_q;
   logic [3:0] sts_m_q, sts_s_q;

   // Reset asserts asynchronously; the pipe holds the FSM in reset until two clean edges pass.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rst_pipe_q <= 2'b11;
         sts_m_q    <= 4'b0000;
         sts_s_q    <= 4'b0000;
      end else begin
         rst_pipe_q <= {rst_pipe_q[0], 1'b0};
         sts_m_q    <= sts;
         sts_s_q    <= sts_m_q;
      end
   end

`ifdef CLK_SW_TIMEOUT_EN
   logic [7:0] tmo_q, tmo_d;
   logic       tmo_hit;
   assign tmo_hit = ((tmo_q + 8'd1) == 8'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) tmo_q <= 8'd0;
      else     tmo_q <= tmo_d;
   end
`else
   logic       tmo_hit;
   logic       unused_err_clr;
   logic [7:0] unused_tmo_lim;
   assign tmo_hit        = 1'b0;
   assign unused_err_clr = err_clr;
   assign unused_tmo_lim = 8'(TIMEOUT_CYCLES);
`endif

   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      en_d      = en_q;
      cur_sel_d = cur_sel_q;
      done_d    = 1'b0;
      dwell_d   = dwell_q;
      err_d     = err_q;
`ifdef CLK_SW_TIMEOUT_EN
      tmo_d = tmo_q;
      if (err_clr) err_d = 1'b0;
`else
      err_d = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (req_sel == cur_sel_q) begin
                  done_d = 1'b1;
               end else begin
                  target_d = req_sel;
                  en_d     = 4'b0000;
                  state_d  = ST_DISABLE;
`ifdef CLK_SW_TIMEOUT_EN
                  tmo_d = 8'd0;
`endif
               end
            end
         end
         ST_DISABLE: begin
            if (!sts_s_q[cur_sel_q]) begin
               en_d    = onehot(target_q);
               state_d = ST_ENABLE;
`ifdef CLK_SW_TIMEOUT_EN
               tmo_d = 8'd0;
`endif
            end else if (tmo_hit) begin
               // Old source never stopped: fall back to it rather than leave the mux dark.
               en_d    = onehot(cur_sel_q);
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
`ifdef CLK_SW_TIMEOUT_EN
               tmo_d = tmo_q + 8'd1;
`endif
            end
         end
         ST_ENABLE: begin
            if (sts_s_q[target_q]) begin
               cur_sel_d = target_q;
               dwell_d   = 8'(DWELL_CYCLES - 1);
               state_d   = ST_SETTLE;
            end else if (tmo_hit) begin
               cur_sel_d = target_q;
               err_d     = 1'b1;
               state_d   = ST_IDLE;
            end else begin
`ifdef CLK_SW_TIMEOUT_EN
               tmo_d = tmo_q + 8'd1;
`endif
            end
         end
         ST_SETTLE: begin
            if (dwell_q == 8'd0) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               dwell_d = dwell_q - 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (rst_pipe_q[1]) begin
         state_d   = ST_IDLE;
         target_d  = 2'd0;
         en_d      = 4'b0001;
         cur_sel_d = 2'd0;
         done_d    = 1'b0;
         err_d     = 1'b0;
         dwell_d   = 8'd0;
`ifdef CLK_SW_TIMEOUT_EN
         tmo_d = 8'd0;
`endif
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         target_q  <= 2'd0;
         en_q      <= 4'b0001;
         cur_sel_q <= 2'd0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         dwell_q   <= 8'd0;
      end else begin
         state_q   <= state_d;
         target_q  <= target_d;
         en_q      <= en_d;
         cur_sel_q <= cur_sel_d;
         done_q    <= done_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         dwell_q   <= dwell_d;
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign en        = en_q;
   assign cur_sel   = cur_sel_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_sw_ctrl.sv
// ============================================================================
// tb_clk_sw_ctrl : self-checking bench for clk_sw_ctrl with a delayed mux model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_clk_sw_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic [1:0] req_sel = 2'd0;
   logic       req_ready;
   logic [3:0] sts;
   logic [3:0] en;
   logic [1:0] cur_sel;
   logic       busy, done, err;
   logic       err_clr = 1'b0;

   clk_sw_ctrl #(.DWELL_CYCLES(8), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel),
      .req_ready(req_ready), .sts(sts), .en(en), .cur_sel(cur_sel),
      .busy(busy), .done(done), .err(err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   // Mux model: each running flag follows its enable three clock edges later.
   logic [3:0] en_h1 = 4'b0001, en_h2 = 4'b0001, en_h3 = 4'b0001;
   logic       stuck0 = 1'b0;
   always @(posedge clk) begin
      en_h1 <= en;
      en_h2 <= en_h1;
      en_h3 <= en_h2;
   end
   assign sts = en_h3 | {3'b000, stuck0};

   int n_pass = 0, n_total = 0;
   logic [1:0] exp_sel_q[$];
   logic [3:0] exp_en_q[$];
   logic [1:0] obs_sel_q[$];
   logic [3:0] obs_en_q[$];
   logic [3:0] en_trace[$];
   int done_cnt = 0, multi_hot = 0, direct_sw = 0, busy_bad = 0;
   logic [3:0] prev_en = 4'b0001, last_tr = 4'b0001;

   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt++;
         obs_sel_q.push_back(cur_sel);
         obs_en_q.push_back(en);
      end
      if ($countones(en) > 1) multi_hot++;
      if (prev_en != 4'b0000 && en != 4'b0000 && en !== prev_en) direct_sw++;
      prev_en = en;
      if (busy !== !req_ready) busy_bad++;
      if (en !== last_tr) begin
         en_trace.push_back(en);
         last_tr = en;
      end
   end

   task automatic request(input logic [1:0] sel);
      int k = 0;
      @(negedge clk);
      while (!req_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      n_total++;
      if (req_ready !== 1'b1) $display("FAIL request_ready: req_ready=%b required 1", req_ready);
      else n_pass++;
      req_valid = 1'b1;
      req_sel   = sel;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_obs(input int bound, output bit got);
      int k = 0;
      while (obs_sel_q.size() == 0 && k < bound) begin
         @(negedge clk);
         k++;
      end
      got = (obs_sel_q.size() != 0);
   endtask

   task automatic pop_compare(input string name);
      logic [1:0] es, os;
      logic [3:0] ee, oe;
      n_total++;
      if (exp_sel_q.size() == 0 || obs_sel_q.size() == 0) begin
         $display("FAIL %s_sb: exp entries=%0d obs entries=%0d required both >0",
                  name, exp_sel_q.size(), obs_sel_q.size());
      end else begin
         es = exp_sel_q.pop_front(); ee = exp_en_q.pop_front();
         os = obs_sel_q.pop_front(); oe = obs_en_q.pop_front();
         if (os !== es || oe !== ee)
            $display("FAIL %s_sb: cur_sel=%0d en=%b required cur_sel=%0d en=%b", name, os, oe, es, ee);
         else n_pass++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      n_total++; if (en !== 4'b0001) $display("FAIL reset_en: en=%b required 0001", en); else n_pass++;
      n_total++; if (cur_sel !== 2'd0) $display("FAIL reset_cur_sel: %0d required 0", cur_sel); else n_pass++;
      n_total++; if (req_ready !== 1'b1) $display("FAIL reset_ready: %b required 1", req_ready); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: %b required 0", busy); else n_pass++;
      n_total++; if (err !== 1'b0) $display("FAIL reset_err: %b required 0", err); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL reset_done: %b required 0", done); else n_pass++;
   endtask

   task automatic test_same_source;
      request(2'd0);
      exp_sel_q.push_back(2'd0); exp_en_q.push_back(4'b0001);
      @(negedge clk);
      n_total++; if (done !== 1'b1) $display("FAIL same_done_pulse: done=%b required 1", done); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL same_busy: busy=%b required 0", busy); else n_pass++;
      n_total++; if (en !== 4'b0001) $display("FAIL same_en: en=%b required 0001", en); else n_pass++;
      @(negedge clk);
      n_total++; if (done !== 1'b0) $display("FAIL same_done_width: done=%b required 0", done); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL same_busy2: busy=%b required 0", busy); else n_pass++;
      pop_compare("same");
   endtask

   task automatic test_switch;
      int bd = done_cnt, bm = multi_hot, bs = direct_sw, bb = busy_bad;
      int tb = en_trace.size();
      bit got;
      request(2'd2);
      exp_sel_q.push_back(2'd2); exp_en_q.push_back(4'b0100);
      @(negedge clk);
      n_total++; if (en !== 4'b0000 || busy !== 1'b1)
         $display("FAIL switch_disable: en=%b busy=%b required en=0000 busy=1", en, busy); else n_pass++;
      wait_obs(200, got);
      n_total++; if (!got) $display("FAIL switch_timeout: done seen=0 required 1"); else n_pass++;
      pop_compare("switch");
      repeat (10) @(negedge clk);
      n_total++; if (done_cnt - bd != 1) $display("FAIL switch_done_count: %0d required 1", done_cnt - bd); else n_pass++;
      n_total++; if (multi_hot - bm != 0) $display("FAIL switch_multi_hot: %0d cycles required 0", multi_hot - bm); else n_pass++;
      n_total++; if (direct_sw - bs != 0) $display("FAIL switch_direct: %0d required 0", direct_sw - bs); else n_pass++;
      n_total++; if (en_trace.size() != tb + 2 || en_trace[tb] !== 4'b0000 || en_trace[tb+1] !== 4'b0100)
         $display("FAIL switch_en_trace: %0d changes required 2 (0000 then 0100)", en_trace.size() - tb);
      else n_pass++;
      n_total++; if (cur_sel !== 2'd2 || err !== 1'b0 || busy !== 1'b0)
         $display("FAIL switch_final: cur_sel=%0d err=%b busy=%b required 2/0/0", cur_sel, err, busy); else n_pass++;
      n_total++; if (busy_bad - bb != 0) $display("FAIL switch_busy_state: %0d required 0", busy_bad - bb); else n_pass++;
   endtask

   task automatic test_back_to_back;
      int bd = done_cnt;
      bit got;
      request(2'd1);
      exp_sel_q.push_back(2'd1); exp_en_q.push_back(4'b0010);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         req_valid = 1'b1;
         req_sel   = 2'd3;
      end
      @(negedge clk);
      req_valid = 1'b0;
      wait_obs(200, got);
      n_total++; if (!got) $display("FAIL b2b_timeout: done seen=0 required 1"); else n_pass++;
      pop_compare("b2b");
      repeat (20) @(negedge clk);
      n_total++; if (done_cnt - bd != 1) $display("FAIL b2b_done_count: %0d required 1", done_cnt - bd); else n_pass++;
      n_total++; if (cur_sel !== 2'd1 || en !== 4'b0010)
         $display("FAIL b2b_final: cur_sel=%0d en=%b required 1/0010", cur_sel, en); else n_pass++;
   endtask

   task automatic test_reset_mid_switch;
      int bd = done_cnt;
      int k = 0;
      request(2'd3);
      while (en !== 4'b1000 && k < 100) begin
         @(negedge clk);
         k++;
      end
      n_total++; if (en !== 4'b1000) $display("FAIL midrst_enable: en=%b required 1000", en); else n_pass++;
      rst = 1'b1;
      #1;
      n_total++; if (en !== 4'b0001 || cur_sel !== 2'd0 || busy !== 1'b0 || req_ready !== 1'b1)
         $display("FAIL midrst_async: en=%b cur_sel=%0d busy=%b ready=%b required 0001/0/0/1",
                  en, cur_sel, busy, req_ready);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      n_total++; if (done_cnt - bd != 0) $display("FAIL midrst_done: %0d pulses required 0", done_cnt - bd); else n_pass++;
      n_total++; if (en !== 4'b0001 || cur_sel !== 2'd0 || busy !== 1'b0)
         $display("FAIL midrst_final: en=%b cur_sel=%0d busy=%b required 0001/0/0", en, cur_sel, busy); else n_pass++;
   endtask

   task automatic test_err;
`ifdef CLK_SW_TIMEOUT_EN
      int bd = done_cnt;
      int k = 0;
      stuck0 = 1'b1;
      request(2'd1);
      while (err !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      n_total++; if (err !== 1'b1) $display("FAIL tmo_err: err=%b required 1", err); else n_pass++;
      n_total++; if (en !== 4'b0001 || cur_sel !== 2'd0 || busy !== 1'b0)
         $display("FAIL tmo_restore: en=%b cur_sel=%0d busy=%b required 0001/0/0", en, cur_sel, busy); else n_pass++;
      repeat (3) @(negedge clk);
      n_total++; if (done_cnt - bd != 0 || err !== 1'b1)
         $display("FAIL tmo_sticky: done=%0d err=%b required 0/1", done_cnt - bd, err); else n_pass++;
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      n_total++; if (err !== 1'b0) $display("FAIL tmo_clear: err=%b required 0", err); else n_pass++;
      stuck0 = 1'b0;
`else
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      n_total++; if (err !== 1'b0) $display("FAIL err_tied: err=%b required 0", err); else n_pass++;
`endif
   endtask

   initial begin
      test_reset();
      test_same_source();
      test_switch();
      test_back_to_back();
      test_reset_mid_switch();
      test_err();
      n_total++;
      if (obs_sel_q.size() != 0 || exp_sel_q.size() != 0)
         $display("FAIL sb_leftover: obs=%0d exp=%0d required 0/0", obs_sel_q.size(), exp_sel_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached required completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/clk_sw_ctrl.md
CLK_SW_CTRL -- requirements
Module: clk_sw_ctrl

Interface
REQ-001 Parameter DWELL_CYCLES, default 8, minimum cycles held in SETTLE after a new source is confirmed (range 1..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 255, cycles allowed per DISABLE/ENABLE wait before error (range 4..255).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  switch request valid.
REQ-006 req_sel  input  2  requested clock source index 0..3.
REQ-007 req_ready  output  1  controller can accept a request.
REQ-008 sts  input  4  per-source "clock running" status from the glitch-free mux (asynchronous to clk).
REQ-009 en  output  4  one-hot (or all-zero) per-source enable to the mux.
REQ-010 cur_sel  output  2  index of the currently confirmed source.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse on a successful switch or same-source request.
REQ-013 err  output  1  sticky timeout flag.
REQ-014 err_clr  input  1  synchronous clear of err.

Function
REQ-015 sts SHALL pass through a 2-flop synchronizer per bit; all decisions use synchronized sts_s.
REQ-016 FSM states: IDLE, DISABLE, ENABLE, SETTLE.
REQ-017 req_ready SHALL equal (state==IDLE); a request is accepted in the cycle where req_valid && req_ready.
REQ-018 Accepted req_sel == cur_sel: no en change, done=1 the following cycle, state stays IDLE.
REQ-019 Accepted req_sel != cur_sel: target latched; next cycle en=0000 and state=DISABLE.
REQ-020 DISABLE -> ENABLE when sts_s[cur_sel]==0; en=one-hot(target) registered on the transition.
REQ-021 ENABLE -> SETTLE when sts_s[target]==1; cur_sel=target on the same edge; dwell counter loaded with DWELL_CYCLES-1.
REQ-022 SETTLE decrements the counter; at 0 -> IDLE with done=1 for exactly one cycle.
REQ-023 At most one en bit SHALL be high in any cycle; en SHALL never go directly from one source to another.
REQ-024 req_valid while busy SHALL be ignored (not queued); requesters hold req_valid until req_ready.
REQ-025 req_sel is sampled only on acceptance; later changes do not affect an in-progress switch.
REQ-026 err_clr clears err next cycle; if a timeout sets err in the same cycle, set wins.
REQ-027 busy is registered and SHALL be identical to (state!=IDLE).

Reset
REQ-028 On rst: state=IDLE, en=0001, cur_sel=0, done=0, err=0, dwell/timeout counters=0, synchronizers=0.
REQ-029 rst asserted mid-switch SHALL abort immediately to the reset values; no done pulse.
REQ-030 Reset deassertion is synchronized internally (assert async, release on clk edge).

Configuration
REQ-031 Macro CLK_SW_TIMEOUT_EN defined: a timeout counter resets on entry to DISABLE and to ENABLE and increments each cycle in those states.
REQ-032 With CLK_SW_TIMEOUT_EN, DISABLE timeout (count reaches TIMEOUT_CYCLES): en restored to one-hot(cur_sel), err=1, state=IDLE, no done.
REQ-033 With CLK_SW_TIMEOUT_EN, ENABLE timeout: en kept at target, cur_sel=target, err=1, state=IDLE, no done.
REQ-034 CLK_SW_TIMEOUT_EN undefined: no timeout counter; DISABLE/ENABLE wait indefinitely; err tied 0; err_clr ignored.

Verification
REQ-035 Reset, sts=0001 -> en=0001, cur_sel=0, req_ready=1, busy=0, err=0.
REQ-036 req_sel=2, mux model drops sts[0] 3 cycles after en[0]=0 and raises sts[2] 3 cycles after en[2]=1, DWELL_CYCLES=8 -> en 0001->0000->0100, never two bits high, cur_sel=2, one done pulse, err=0.
REQ-037 req_sel=0 while cur_sel=0 -> en unchanged, done high exactly 1 cycle after acceptance, busy stays 0.
REQ-038 Second req_valid (req_sel=3) during busy switch to 1 -> ignored; final cur_sel=1, exactly one done.
REQ-039 CLK_SW_TIMEOUT_EN, TIMEOUT_CYCLES=16, sts[0] stuck 1, req_sel=1 -> en back to 0001, err=1, cur_sel=0, no done; err_clr -> err=0.
REQ-040 rst pulsed while in ENABLE toward source 3 -> en=0001, cur_sel=0, state IDLE, no done.
